// File: rtl/skinny_pkg.sv
// Shared definitions for the SKINNY-128-384 round controller:
// FSM encoding, round-constant width, default round count and the
// 6-bit round-constant LFSR step.
package skinny_pkg;

  localparam int SKINNY_RC_W = 6;
  localparam int ROUNDS      = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // One step of the round-constant LFSR; starting from 0 the first value is 6'h01.
  function automatic logic [SKINNY_RC_W-1:0] lfsr_step(input logic [SKINNY_RC_W-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/skinny_rnd.sv
// Combinational SKINNY-128-384 round datapath: applies numrnd rounds
// (SubCells, AddConstants, AddRoundTweakey, ShiftRows, MixColumns) and the
// matching tweakey schedule. Cell 0 is the most significant byte.
// With fullcnt=0 the TK1 register holds only the upper eight cells; the lower
// half of TK1 is zero and returns to zero after every pair of rounds, so an
// even numrnd keeps the half counter exact.
module skinny_rnd
  import skinny_pkg::*;
#(
  parameter int numrnd  = 2,
  parameter int fullcnt = 1
) (
  input  logic [127:0]                   state,
  input  logic [127:0]                   key,
  input  logic [127:0]                   tweak,
  input  logic [63+64*fullcnt:0]         cnt,
  input  logic [SKINNY_RC_W*numrnd-1:0]  rc,
  output logic [127:0]                   nextstate,
  output logic [127:0]                   nextkey,
  output logic [127:0]                   nexttweak,
  output logic [63+64*fullcnt:0]         nextcnt
);

  localparam int CW = 64 + 64 * fullcnt;
  localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int k = 0; k < 4; k++) begin
      x[0] = x[0] ^ ~(x[3] | x[2]);
      x[4] = x[4] ^ ~(x[7] | x[6]);
      if (k < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [63:0] rtk,
                                            input logic [5:0] c);
    logic [127:0] a, b, m;
    for (int i = 0; i < 16; i++) a[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    a[123:120] = a[123:120] ^ c[3:0];
    a[89:88]   = a[89:88] ^ c[5:4];
    a[57]      = ~a[57];
    a[127:64]  = a[127:64] ^ rtk;
    // Row r rotates right by r cells.
    b[127:96] = a[127:96];
    b[95:64]  = {a[71:64], a[95:72]};
    b[63:32]  = {a[47:32], a[63:48]};
    b[31:0]   = {a[23:0], a[31:24]};
    m[127:96] = b[127:96] ^ b[63:32] ^ b[31:0];
    m[95:64]  = b[127:96];
    m[63:32]  = b[95:64] ^ b[63:32];
    m[31:0]   = b[127:96] ^ b[63:32];
    return m;
  endfunction

  function automatic logic [127:0] tk_perm(input logic [127:0] t);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[127-8*PT[i] -: 8];
    return o;
  endfunction

  function automatic logic [127:0] tk2_upd(input logic [127:0] t);
    logic [127:0] o;
    logic [7:0]   x;
    o = tk_perm(t);
    for (int i = 0; i < 8; i++) begin
      x = o[127-8*i -: 8];
      o[127-8*i -: 8] = {x[6:0], x[7] ^ x[5]};
    end
    return o;
  endfunction

  function automatic logic [127:0] tk3_upd(input logic [127:0] t);
    logic [127:0] o;
    logic [7:0]   x;
    o = tk_perm(t);
    for (int i = 0; i < 8; i++) begin
      x = o[127-8*i -: 8];
      o[127-8*i -: 8] = {x[0] ^ x[6], x[7:1]};
    end
    return o;
  endfunction

  // Chain numrnd rounds together with the tweakey schedule.
  always_comb begin
    logic [127:0] s, t1, t2, t3;
    s  = state;
    t1 = 128'(cnt) << (128 - CW);
    t2 = tweak;
    t3 = key;
    for (int r = 0; r < numrnd; r++) begin
      s  = round_fn(s, t1[127:64] ^ t2[127:64] ^ t3[127:64], rc[SKINNY_RC_W*r +: SKINNY_RC_W]);
      t1 = tk_perm(t1);
      t2 = tk2_upd(t2);
      t3 = tk3_upd(t3);
    end
    nextstate = s;
    nextkey   = t3;
    nexttweak = t2;
    nextcnt   = t1[127 -: CW];
  end

endmodule

// File: rtl/skinny_rnd_ctrl.sv
// Iterative SKINNY-128-384 encryption controller: holds state/TK3/TK2/TK1
// registers, runs NUMRND rounds per clock through skinny_rnd, generates the
// round constants and hands one ciphertext at a time out over valid/ready.
// Optional build macro SKINNY_CTRL_ZEROIZE_EN: clears the block registers on
// the output handshake and blanks state_out while no result is offered.
module skinny_rnd_ctrl #(
  parameter int NUMRND  = 2,
  parameter int FULLCNT = 1,
  parameter int ROUNDS  = skinny_pkg::ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            state_in,
  input  logic [127:0]            key_in,
  input  logic [127:0]            tweak_in,
  input  logic [63+64*FULLCNT:0]  cnt_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            state_out,
  output logic                    busy,
  output logic [6*NUMRND-1:0]     rnd_const_o
);

  import skinny_pkg::*;

  localparam int CW = 64 + 64 * FULLCNT;

  fsm_t                           fsm, fsm_nxt;
  logic [127:0]                   state_reg, key_reg, tweak_reg;
  logic [CW-1:0]                  cnt_reg;
  logic [SKINNY_RC_W-1:0]         rc_reg;
  logic [5:0]                     rcnt;
  logic [SKINNY_RC_W*NUMRND-1:0]  lanes;
  logic [127:0]                   nextstate, nextkey, nexttweak;
  logic [CW-1:0]                  nextcnt;
  logic                           accept, last_step;

  assign accept    = (fsm == IDLE) && in_valid;
  assign last_step = (rcnt + 6'(NUMRND)) == 6'(ROUNDS);

  // Unroll the constant LFSR: lane i is rc_reg advanced i+1 steps.
  always_comb begin
    logic [SKINNY_RC_W-1:0] r;
    r     = rc_reg;
    lanes = '0;
    for (int i = 0; i < NUMRND; i++) begin
      r = lfsr_step(r);
      lanes[SKINNY_RC_W*i +: SKINNY_RC_W] = r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // FSM next-state: accept in IDLE, count rounds in RUN, wait for the consumer in DONE.
  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (in_valid)  fsm_nxt = RUN;
      RUN:     if (last_step) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready    = (fsm == IDLE);
    busy        = (fsm == RUN);
    out_valid   = (fsm == DONE);
    rnd_const_o = (fsm == RUN) ? lanes : '0;
  end

`ifdef SKINNY_CTRL_ZEROIZE_EN
  assign state_out = (fsm == DONE) ? state_reg : '0;
`else
  assign state_out = state_reg;
`endif

  // Block registers: load on accept, step through the datapath while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      tweak_reg <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      state_reg <= state_in;
      key_reg   <= key_in;
      tweak_reg <= tweak_in;
      cnt_reg   <= cnt_in;
    end else if (fsm == RUN) begin
      state_reg <= nextstate;
      key_reg   <= nextkey;
      tweak_reg <= nexttweak;
      cnt_reg   <= nextcnt;
`ifdef SKINNY_CTRL_ZEROIZE_EN
    end else if ((fsm == DONE) && out_ready) begin
      state_reg <= '0;
      key_reg   <= '0;
      tweak_reg <= '0;
      cnt_reg   <= '0;
`endif
    end
  end

  // Round constant and round counter: cleared on accept, advanced NUMRND per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_reg <= '0;
      rcnt   <= '0;
    end else if (accept) begin
      rc_reg <= '0;
      rcnt   <= '0;
    end else if (fsm == RUN) begin
      rc_reg <= lanes[SKINNY_RC_W*NUMRND-1 -: SKINNY_RC_W];
      rcnt   <= rcnt + 6'(NUMRND);
    end
  end

  skinny_rnd #(
    .numrnd  (NUMRND),
    .fullcnt (FULLCNT)
  ) u_rnd (
    .state     (state_reg),
    .key       (key_reg),
    .tweak     (tweak_reg),
    .cnt       (cnt_reg),
    .rc        (rnd_const_o),
    .nextstate (nextstate),
    .nextkey   (nextkey),
    .nexttweak (nexttweak),
    .nextcnt   (nextcnt)
  );

endmodule

// File: tb/tb_skinny_rnd_ctrl.sv
// Bench for skinny_rnd_ctrl: a full-counter instance and a half-counter
// instance driven in lockstep, checked against a byte-level SKINNY-128-384
// reference model with 40 rounds.
module tb_skinny_rnd_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [127:0] state_in, key_in, tweak_in, cnt_in;
  logic [63:0]  cnt_h;

  logic         in_ready, out_valid, busy;
  logic [127:0] state_out;
  logic [11:0]  rnd_const_o;
  logic         in_ready_h, out_valid_h, busy_h;
  logic [127:0] state_out_h;
  logic [11:0]  rnd_const_h;

  int           total = 0;
  int           bad   = 0;
  logic [5:0]   rcs [0:63];

  always #5 clk = ~clk;

  skinny_rnd_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .key_in(key_in), .tweak_in(tweak_in), .cnt_in(cnt_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
    .busy(busy), .rnd_const_o(rnd_const_o)
  );

  skinny_rnd_ctrl #(.FULLCNT(0)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
    .state_in(state_in), .key_in(key_in), .tweak_in(tweak_in), .cnt_in(cnt_h),
    .out_valid(out_valid_h), .out_ready(out_ready), .state_out(state_out_h),
    .busy(busy_h), .rnd_const_o(rnd_const_h)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] x, y;
    int dst [8];
    dst = '{2, 6, 7, 1, 3, 0, 4, 5};
    x = v;
    for (int r = 0; r < 4; r++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (r < 3) begin
        y = 8'h00;
        for (int j = 0; j < 8; j++) y[dst[j]] = x[j];
        x = y;
      end
    end
    y = x;
    y[1] = x[2];
    y[2] = x[1];
    return y;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k1,
                                           input logic [127:0] k2, input logic [127:0] k3,
                                           input int nr);
    logic [7:0] s [16];
    logic [7:0] t1 [16];
    logic [7:0] t2 [16];
    logic [7:0] t3 [16];
    logic [7:0] o [16];
    logic [7:0] a0, a1, a2, a3, x;
    logic [5:0] rc;
    logic [127:0] res;
    int perm [16];
    perm = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 16; i++) begin
      s[i]  = pt[127-8*i -: 8];
      t1[i] = k1[127-8*i -: 8];
      t2[i] = k2[127-8*i -: 8];
      t3[i] = k3[127-8*i -: 8];
    end
    rc = 6'h00;
    for (int r = 0; r < nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = ref_sbox(s[i]);
      rc = {rc[4:0], ~(rc[5] ^ rc[4])};
      s[0] = s[0] ^ {4'h0, rc[3:0]};
      s[4] = s[4] ^ {6'h00, rc[5:4]};
      s[8] = s[8] ^ 8'h02;
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ t1[i] ^ t2[i] ^ t3[i];
      for (int i = 0; i < 16; i++) o[i] = s[4*(i/4) + ((i%4) + 4 - (i/4)) % 4];
      s = o;
      for (int c = 0; c < 4; c++) begin
        a0 = s[c]; a1 = s[4+c]; a2 = s[8+c]; a3 = s[12+c];
        s[c]    = a0 ^ a2 ^ a3;
        s[4+c]  = a0;
        s[8+c]  = a1 ^ a2;
        s[12+c] = a0 ^ a2;
      end
      for (int i = 0; i < 16; i++) o[i] = t1[perm[i]];
      t1 = o;
      for (int i = 0; i < 16; i++) o[i] = t2[perm[i]];
      t2 = o;
      for (int i = 0; i < 16; i++) o[i] = t3[perm[i]];
      t3 = o;
      for (int i = 0; i < 8; i++) begin
        x = t2[i]; t2[i] = {x[6:0], x[7] ^ x[5]};
        x = t3[i]; t3[i] = {x[0] ^ x[6], x[7:1]};
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic randomize_in();
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    tweak_in = {$urandom, $urandom, $urandom, $urandom};
    cnt_in   = {$urandom, $urandom, $urandom, $urandom};
    cnt_h    = {$urandom, $urandom};
  endtask

  // Called at a negedge with both controllers idle; returns at the negedge of RUN cycle 1.
  task automatic send_block(output logic [127:0] ef, output logic [127:0] eh);
    randomize_in();
    ef = ref_enc(state_in, cnt_in, tweak_in, key_in, 40);
    eh = ref_enc(state_in, {cnt_h, 64'h0}, tweak_in, key_in, 40);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_block(input logic [127:0] ef, input logic [127:0] eh, input string tag);
    int n;
    n = 0;
    while (!(out_valid && out_valid_h) && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(out_valid && out_valid_h)) begin
      bad++;
      $display("FAIL %s out_valid timeout: got %b/%b after %0d cycles, want 1/1", tag, out_valid, out_valid_h, n);
    end
    total++;
    if (state_out !== ef) begin
      bad++;
      $display("FAIL %s ciphertext full: got %h want %h", tag, state_out, ef);
    end
    total++;
    if (state_out_h !== eh) begin
      bad++;
      $display("FAIL %s ciphertext half: got %h want %h", tag, state_out_h, eh);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    state_in = '0; key_in = '0; tweak_in = '0; cnt_in = '0; cnt_h = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, in_ready_h, out_valid_h, busy_h} !== 6'b100100) begin
      bad++;
      $display("FAIL reset flags: got %b want 100100", {in_ready, out_valid, busy, in_ready_h, out_valid_h, busy_h});
    end
    total++;
    if (state_out !== 128'h0 || state_out_h !== 128'h0) begin
      bad++;
      $display("FAIL reset state_out: got %h/%h want 0", state_out, state_out_h);
    end
    total++;
    if (rnd_const_o !== 12'h0 || rnd_const_h !== 12'h0) begin
      bad++;
      $display("FAIL reset rnd_const: got %h/%h want 000", rnd_const_o, rnd_const_h);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constants_latency_hold();
    logic [127:0] ef, eh;
    logic [11:0]  exp_rc;
    send_block(ef, eh);
    for (int k = 1; k <= 20; k++) begin
      exp_rc = {rcs[2*k], rcs[2*k-1]};
      total++;
      if (rnd_const_o !== exp_rc || rnd_const_h !== exp_rc) begin
        bad++;
        $display("FAIL rc_lanes cycle %0d: got %h/%h want %h", k, rnd_const_o, rnd_const_h, exp_rc);
      end
      total++;
      if ({busy, in_ready, out_valid, busy_h, in_ready_h, out_valid_h} !== 6'b100100) begin
        bad++;
        $display("FAIL run_flags cycle %0d: got %b want 100100", k,
                 {busy, in_ready, out_valid, busy_h, in_ready_h, out_valid_h});
      end
      if (k == 1) begin
        total++;
        if (rnd_const_o !== 12'h0C1) begin
          bad++; $display("FAIL rc_first: got %h want 0c1", rnd_const_o);
        end
      end
      if (k == 2) begin
        total++;
        if (rnd_const_o !== 12'h3C7) begin
          bad++; $display("FAIL rc_second: got %h want 3c7", rnd_const_o);
        end
      end
      if (k == 20) begin
        total++;
        if (rnd_const_o !== 12'h6AD) begin
          bad++; $display("FAIL rc_last: got %h want 6ad", rnd_const_o);
        end
      end
      @(negedge clk);
    end
    total++;
    if ({out_valid, out_valid_h, busy, busy_h} !== 4'b1100) begin
      bad++;
      $display("FAIL latency: out_valid/busy got %b want 1100 at 20 cycles after accept",
               {out_valid, out_valid_h, busy, busy_h});
    end
    // Hold five cycles with no consumer; a new in_valid must be ignored meanwhile.
    in_valid = 1'b1;
    randomize_in();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (state_out !== ef || state_out_h !== eh || !out_valid || !out_valid_h || in_ready || in_ready_h) begin
        bad++;
        $display("FAIL hold cycle %0d: got %h/%h ov=%b%b ir=%b%b want %h/%h ov=11 ir=00", k,
                 state_out, state_out_h, out_valid, out_valid_h, in_ready, in_ready_h, ef, eh);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, in_ready_h, out_valid, out_valid_h} !== 4'b1100) begin
      bad++;
      $display("FAIL release: in_ready/out_valid got %b want 1100", {in_ready, in_ready_h, out_valid, out_valid_h});
    end
`ifdef SKINNY_CTRL_ZEROIZE_EN
    total++;
    if (state_out !== 128'h0 || state_out_h !== 128'h0) begin
      bad++;
      $display("FAIL zeroize state_out: got %h/%h want 0", state_out, state_out_h);
    end
    total++;
    if (dut.key_reg !== 128'h0 || dut_h.key_reg !== 128'h0) begin
      bad++;
      $display("FAIL zeroize key: got %h/%h want 0", dut.key_reg, dut_h.key_reg);
    end
`else
    total++;
    if (state_out !== ef || state_out_h !== eh) begin
      bad++;
      $display("FAIL retain state_out: got %h/%h want %h/%h", state_out, state_out_h, ef, eh);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    logic [127:0] ef, eh;
    send_block(ef, eh);
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        in_valid = 1'b1;
        randomize_in();
      end else if (k == 6) begin
        in_valid = 1'b0;
      end
      total++;
      if (in_ready || in_ready_h) begin
        bad++;
        $display("FAIL busy_in_ready cycle %0d: got %b%b want 00", k, in_ready, in_ready_h);
      end
      @(negedge clk);
    end
    finish_block(ef, eh, "busy_ignore");
  endtask

  task automatic test_mid_reset();
    logic [127:0] ef, eh;
    send_block(ef, eh);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, out_valid, in_ready, busy_h, out_valid_h, in_ready_h} !== 6'b001001) begin
      bad++;
      $display("FAIL midreset flags: got %b want 001001", {busy, out_valid, in_ready, busy_h, out_valid_h, in_ready_h});
    end
    total++;
    if (rnd_const_o !== 12'h0 || rnd_const_h !== 12'h0 || state_out !== 128'h0) begin
      bad++;
      $display("FAIL midreset data: rc %h/%h state %h want 000/000 0", rnd_const_o, rnd_const_h, state_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block(ef, eh);
    finish_block(ef, eh, "after_reset");
  endtask

  task automatic test_stream();
    logic [127:0] qf [$];
    logic [127:0] qh [$];
    logic [127:0] wf, wh;
    int cyc, nacc, nout, last_acc;
    logic need_new;
    cyc = 0; nacc = 0; nout = 0; last_acc = 0; need_new = 1'b0;
    randomize_in();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nout < 6 && cyc < 400) begin
      if (need_new) begin
        need_new = 1'b0;
        if (nacc >= 6) in_valid = 1'b0;
        else randomize_in();
      end
      if (out_valid) begin
        total++;
        if (qf.size() == 0) begin
          bad++;
          $display("FAIL stream unexpected out_valid at cycle %0d: got 1 want 0", cyc);
        end else begin
          wf = qf.pop_front();
          wh = qh.pop_front();
          if (state_out !== wf || state_out_h !== wh) begin
            bad++;
            $display("FAIL stream ciphertext %0d: got %h/%h want %h/%h", nout, state_out, state_out_h, wf, wh);
          end
        end
        nout++;
      end
      if (in_ready && in_valid) begin
        if (nacc > 0) begin
          total++;
          if (cyc - last_acc != 22) begin
            bad++;
            $display("FAIL stream period: got %0d cycles want 22", cyc - last_acc);
          end
        end
        qf.push_back(ref_enc(state_in, cnt_in, tweak_in, key_in, 40));
        qh.push_back(ref_enc(state_in, {cnt_h, 64'h0}, tweak_in, key_in, 40));
        last_acc = cyc;
        nacc++;
        need_new = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (nout != 6) begin
      bad++;
      $display("FAIL stream count: got %0d blocks want 6", nout);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rcs[0] = 6'h00;
    for (int i = 1; i < 64; i++) rcs[i] = {rcs[i-1][4:0], ~(rcs[i-1][5] ^ rcs[i-1][4])};
    test_reset();
    test_constants_latency_hold();
    test_busy_ignore();
    test_mid_reset();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skinny_rnd_ctrl.md
# skinny_rnd_ctrl

Iterative SKINNY-128-384 encryption controller for the Romulus core. It owns the state, TK3 key, TK2 tweak and TK1 counter registers, and applies the combinational round datapath `NUMRND` rounds per clock. It generates the 6-bit LFSR round constants and counts rounds to `ROUNDS`. One block is processed at a time, with valid/ready handshakes on input and output.

## Interface
- `NUMRND`, 2, rounds per clock; must divide `ROUNDS`; must be even when `FULLCNT`=0
- `FULLCNT`, 1, 1: 128-bit TK1 counter; 0: 64-bit half counter (expanded every second round)
- `ROUNDS`, 40, total rounds per block
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  input block valid
- `in_ready`  out  1  controller can accept a block
- `state_in`  in  128  plaintext
- `key_in`  in  128  TK3
- `tweak_in`  in  128  TK2
- `cnt_in`  in  64+64*FULLCNT  TK1 counter
- `out_valid`  out  1  ciphertext valid
- `out_ready`  in  1  consumer accepts ciphertext
- `state_out`  out  128  ciphertext
- `busy`  out  1  high in RUN
- `rnd_const_o`  out  6*NUMRND  constants applied this cycle; round i at bits [6i+5:6i]

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:**
  - `in_ready`=1; `out_valid`=0; `busy`=0; `state_out`=0.
  - All data registers are 0; `rc`=6'h00; round counter `rcnt`=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: load all four registers from the inputs, clear `rc`/`rcnt`, go to RUN.
- **RUN:**
  - `in_ready`=0; `busy`=1.
  - Each cycle, the state/key/tweak/cnt registers take the datapath's next values.
  - `rc` advances `NUMRND` LFSR steps.
  - `rcnt` += `NUMRND`. When `rcnt`+`NUMRND`==`ROUNDS`, go to DONE.
- **DONE:**
  - `out_valid`=1; `state_out` = state register, held stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored in DONE.
- **LFSR step:** rc' = {rc[4:0], rc[5]^rc[4]^1}. The first constant used is 6'h01.
- `rnd_const_o` lane i is the LFSR value after (rcnt+i+1) steps. It is valid in RUN and 0 otherwise.
- `rcnt` is 6 bits and never exceeds `ROUNDS`. It does not wrap.
- Mid-operation reset: asynchronous return to reset values; the in-flight block is dropped silently.
- `in_valid` while not in IDLE: ignored; no register changes.

## Timing
- Acceptance handshake at edge E0. RUN occupies the R = `ROUNDS`/`NUMRND` cycles after E0.
- `out_valid` rises R cycles after E0 (20 for defaults).
- Output handshake at edge Ed. IDLE is entered at Ed; the next block can be accepted at Ed+1.
- Minimum block period: R+2 cycles.
- All outputs come from registers or decode of the FSM state. No combinational path from inputs to outputs.

## Configuration
- `SKINNY_CTRL_ZEROIZE_EN`
  - **Defined:**
    - On the output handshake, the state, key, tweak and cnt registers clear to 0.
    - `state_out` is forced to 0 whenever `out_valid`=0.
  - **Undefined:**
    - Registers retain their last values after the output handshake.
    - `state_out` continuously reflects the state register.

## Structure
- Shared package `skinny_pkg`:
  - FSM state enum (IDLE/RUN/DONE)
  - `SKINNY_RC_W`=6
  - LFSR step function
  - `ROUNDS` default 40
- One sub-module: the existing `skinny_rnd` datapath, instantiated with `numrnd`=`NUMRND` and `fullcnt`=`FULLCNT`.
  - Fed from the registers and `rnd_const_o`.
  - Its outputs nextstate/nextkey/nexttweak/nextcnt load the registers.
- The constant unroller, FSM and round counter live in the top module.

## Test plan
- Constants, default params: accept a block.
  - RUN cycle 1: `rnd_const_o`=12'h0C1.
  - Cycle 2: 12'h3C7.
  - Cycle 20: 12'h6AD (rounds 39/40 = 2D/1A).
- Latency/hold: `in_valid` at E0 with `out_ready`=0.
  - `out_valid` rises 20 cycles after E0.
  - `out_ready` is held 0 for 5 cycles: `state_out` stays stable and `out_valid` stays 1.
  - Then `out_ready`=1: `in_ready`=1 the next cycle.
- Busy ignore: pulse `in_valid` with new data during RUN cycle 5.
  - `in_ready`=0 throughout.
  - The result equals the unperturbed golden ciphertext.
- Mid-run reset: assert `rst` in RUN cycle 7.
  - Immediately: `busy`=0, `out_valid`=0, `in_ready`=1, `rnd_const_o`=0.
  - The next block after reset produces the correct ciphertext.
- Streaming: `in_valid` and `out_ready` held at 1.
  - A block is accepted every 22 cycles.
  - Ciphertexts match the software Romulus/SKINNY-128-384+ model for random inputs, with `FULLCNT`=1 and also `FULLCNT`=0.
- Zeroize (macro defined): after the output handshake, `state_out`=0 and the internal key register=0.
